// File: rtl/mem_req_ctrl.sv
// Single-outstanding memory request controller: accepts one pipeline request,
// drives one memory access, returns one response, and latches fatal errors.
module mem_req_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wr_i,
  input  logic [15:0] req_addr_i,
  input  logic [15:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [15:0] resp_rdata_o,
  output logic        resp_hit_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_data_in_o,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  input  logic [15:0] mem_data_out_i,
  input  logic        mem_done_i,
  input  logic        mem_stall_i,
  input  logic        mem_cache_hit_i,
  input  logic        mem_err_i,
  output logic        err_o,
  output logic [15:0] hit_cnt_o,
  output logic [15:0] acc_cnt_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, ERR} state_t;

  state_t        state_q;
  logic          req_ready_q;
  logic          resp_valid_q;
  logic [15:0]   resp_rdata_q;
  logic          resp_hit_q;
  logic [15:0]   mem_addr_q;
  logic [15:0]   mem_data_in_q;
  logic          mem_rd_q;
  logic          mem_wr_q;
  logic          err_q;
  logic [15:0]   hit_cnt_q;
  logic [15:0]   acc_cnt_q;
  logic [TW-1:0] tmo_q;

  logic [15:0]   hit_cnt_d;
  logic [15:0]   acc_cnt_d;

  // Stall is status only; completion is decided solely by mem_done.
  logic unused_stall;
  assign unused_stall = mem_stall_i;

  always_comb begin
    hit_cnt_d = (hit_cnt_q != 16'hFFFF) ? hit_cnt_q + 16'd1 : hit_cnt_q;
    acc_cnt_d = (acc_cnt_q != 16'hFFFF) ? acc_cnt_q + 16'd1 : acc_cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_hit_q    <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      err_q         <= 1'b0;
      hit_cnt_q     <= '0;
      acc_cnt_q     <= '0;
      tmo_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            req_ready_q <= 1'b0;
            if (req_addr_i[0]) begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end else begin
              state_q       <= BUSY;
              mem_addr_q    <= req_addr_i;
              mem_data_in_q <= req_wdata_i;
              mem_rd_q      <= ~req_wr_i;
              mem_wr_q      <= req_wr_i;
              tmo_q         <= '0;
            end
          end
        end
        BUSY: begin
          if (mem_err_i) begin
            state_q  <= ERR;
            err_q    <= 1'b1;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
          end else if (mem_done_i) begin
            state_q      <= RESP;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= mem_wr_q ? 16'h0000 : mem_data_out_i;
            resp_hit_q   <= mem_cache_hit_i;
            acc_cnt_q    <= acc_cnt_d;
            if (mem_cache_hit_i) hit_cnt_q <= hit_cnt_d;
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_q  <= ERR;
            err_q    <= 1'b1;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            tmo_q    <= tmo_q + 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready_i) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          // ERR is terminal until reset.
          state_q <= ERR;
        end
      endcase
    end
  end

  assign req_ready_o   = req_ready_q;
  assign resp_valid_o  = resp_valid_q;
  assign resp_rdata_o  = resp_rdata_q;
  assign resp_hit_o    = resp_hit_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_data_in_o = mem_data_in_q;
  assign mem_rd_o      = mem_rd_q;
  assign mem_wr_o      = mem_wr_q;
  assign err_o         = err_q;
  assign hit_cnt_o     = hit_cnt_q;
  assign acc_cnt_o     = acc_cnt_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: a default-TIMEOUT instance plus a TIMEOUT=8
// instance sharing the same stimulus.
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_wr, resp_ready;
  logic [15:0] req_addr, req_wdata, mem_data_out;
  logic        mem_done, mem_stall, mem_cache_hit, mem_err;

  logic        req_ready, resp_valid, resp_hit, mem_rd, mem_wr, err;
  logic [15:0] resp_rdata, mem_addr, mem_data_in, hit_cnt, acc_cnt;

  logic        t_req_ready, t_resp_valid, t_resp_hit, t_mem_rd, t_mem_wr, t_err;
  logic [15:0] t_resp_rdata, t_mem_addr, t_mem_data_in, t_hit_cnt, t_acc_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_req_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wr_i(req_wr),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_hit_o(resp_hit),
    .mem_addr_o(mem_addr), .mem_data_in_o(mem_data_in),
    .mem_rd_o(mem_rd), .mem_wr_o(mem_wr),
    .mem_data_out_i(mem_data_out), .mem_done_i(mem_done),
    .mem_stall_i(mem_stall), .mem_cache_hit_i(mem_cache_hit),
    .mem_err_i(mem_err), .err_o(err),
    .hit_cnt_o(hit_cnt), .acc_cnt_o(acc_cnt)
  );

  mem_req_ctrl #(.TIMEOUT(8)) dut_t (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(t_req_ready), .req_wr_i(req_wr),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(t_resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(t_resp_rdata), .resp_hit_o(t_resp_hit),
    .mem_addr_o(t_mem_addr), .mem_data_in_o(t_mem_data_in),
    .mem_rd_o(t_mem_rd), .mem_wr_o(t_mem_wr),
    .mem_data_out_i(mem_data_out), .mem_done_i(mem_done),
    .mem_stall_i(mem_stall), .mem_cache_hit_i(mem_cache_hit),
    .mem_err_i(mem_err), .err_o(t_err),
    .hit_cnt_o(t_hit_cnt), .acc_cnt_o(t_acc_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; resp_ready = 1'b0;
    req_addr = '0; req_wdata = '0; mem_data_out = '0;
    mem_done = 1'b0; mem_stall = 1'b0; mem_cache_hit = 1'b0; mem_err = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_err", err, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_acc_cnt", acc_cnt, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_req_ready", req_ready, 1);

    // 1-cycle read hit, latency N+2 / N+3
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0010;
    mem_done = 1'b1; mem_cache_hit = 1'b1; mem_data_out = 16'hBEEF; resp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("rd_mem_rd", mem_rd, 1);
    chk("rd_mem_wr", mem_wr, 0);
    chk("rd_mem_addr", mem_addr, 16'h0010);
    chk("rd_resp_valid_n1", resp_valid, 0);
    tick();
    chk("rd_resp_valid_n2", resp_valid, 1);
    chk("rd_rdata", resp_rdata, 16'hBEEF);
    chk("rd_hit", resp_hit, 1);
    chk("rd_hit_cnt", hit_cnt, 1);
    chk("rd_acc_cnt", acc_cnt, 1);
    chk("rd_req_ready_n2", req_ready, 0);
    chk("rd_mem_rd_off", mem_rd, 0);
    tick();
    chk("rd_req_ready_n3", req_ready, 1);
    chk("rd_resp_valid_n3", resp_valid, 0);
    mem_done = 1'b0; mem_cache_hit = 1'b0;

    // Write with 10 stall cycles then a miss
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0020; req_wdata = 16'h1234;
    mem_stall = 1'b1;
    tick();
    req_valid = 1'b0; req_addr = 16'h0FF0; req_wdata = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      chk("wr_stall_mem_wr", mem_wr, 1);
      chk("wr_stall_mem_rd", mem_rd, 0);
      chk("wr_stall_addr", mem_addr, 16'h0020);
      chk("wr_stall_data", mem_data_in, 16'h1234);
      chk("wr_stall_resp_valid", resp_valid, 0);
      tick();
    end
    mem_stall = 1'b0; mem_done = 1'b1; mem_cache_hit = 1'b0; mem_data_out = 16'h5555;
    chk("wr_cycle11_mem_wr", mem_wr, 1);
    chk("wr_cycle11_addr", mem_addr, 16'h0020);
    tick();
    mem_done = 1'b0;
    chk("wr_resp_valid", resp_valid, 1);
    chk("wr_rdata", resp_rdata, 16'h0000);
    chk("wr_hit", resp_hit, 0);
    chk("wr_hit_cnt", hit_cnt, 1);
    chk("wr_acc_cnt", acc_cnt, 2);
    chk("wr_mem_wr_off", mem_wr, 0);
    chk("wr_addr_hold", mem_addr, 16'h0020);
    tick();

    // Response backpressure for 5 cycles
    resp_ready = 1'b0; req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0040;
    mem_done = 1'b1; mem_cache_hit = 1'b0; mem_data_out = 16'hA5A5;
    tick();
    req_addr = 16'h0060;
    tick();
    mem_done = 1'b0; mem_data_out = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", resp_valid, 1);
      chk("bp_rdata", resp_rdata, 16'hA5A5);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_mem_rd", mem_rd, 0);
      tick();
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    tick();
    chk("bp_release_req_ready", req_ready, 1);
    chk("bp_release_resp_valid", resp_valid, 0);
    chk("bp_acc_cnt", acc_cnt, 3);
    chk("bp_hit_cnt", hit_cnt, 1);
    chk("bp_mem_addr", mem_addr, 16'h0040);

    // mem_err together with mem_done
    req_valid = 1'b1; req_addr = 16'h0080; mem_done = 1'b1; mem_err = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("merr_mem_rd", mem_rd, 1);
    tick();
    mem_done = 1'b0; mem_err = 1'b0;
    chk("merr_err", err, 1);
    chk("merr_resp_valid", resp_valid, 0);
    chk("merr_acc_cnt", acc_cnt, 3);
    chk("merr_mem_rd_off", mem_rd, 0);
    tick(); tick();
    chk("merr_sticky_err", err, 1);
    chk("merr_req_ready", req_ready, 0);

    // Asynchronous reset clears state without a clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("arst_err", err, 0);
    chk("arst_acc_cnt", acc_cnt, 0);
    chk("arst_hit_cnt", hit_cnt, 0);
    chk("arst_mem_addr", mem_addr, 16'h0000);
    tick();
    rst_n = 1'b1;
    tick();

    // Unaligned read
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0003;
    tick();
    req_valid = 1'b0;
    chk("unal_err", err, 1);
    chk("unal_mem_rd", mem_rd, 0);
    chk("unal_mem_wr", mem_wr, 0);
    chk("unal_req_ready", req_ready, 0);
    req_valid = 1'b1; req_addr = 16'h0004;
    tick(); tick();
    req_valid = 1'b0;
    chk("unal_req_ready_held", req_ready, 0);
    chk("unal_mem_rd_held", mem_rd, 0);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Reset asserted mid-BUSY
    req_valid = 1'b1; req_addr = 16'h0100;
    tick();
    req_valid = 1'b0;
    chk("midrst_mem_rd_before", mem_rd, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_mem_rd_after", mem_rd, 0);
    chk("midrst_resp_valid", resp_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    req_valid = 1'b1; req_addr = 16'h0102;
    mem_done = 1'b1; mem_cache_hit = 1'b1; mem_data_out = 16'h7777; resp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("midrst_next_resp_valid", resp_valid, 1);
    chk("midrst_next_rdata", resp_rdata, 16'h7777);
    chk("midrst_next_acc_cnt", acc_cnt, 1);
    chk("midrst_next_hit_cnt", hit_cnt, 1);
    tick();
    mem_done = 1'b0; mem_cache_hit = 1'b0;

    // Timeout on the TIMEOUT=8 instance
    req_valid = 1'b1; req_addr = 16'h0200;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("tmo_busy_rd", t_mem_rd, 1);
      chk("tmo_busy_err", t_err, 0);
      tick();
    end
    chk("tmo_err", t_err, 1);
    chk("tmo_mem_rd_off", t_mem_rd, 0);
    chk("tmo_req_ready", t_req_ready, 0);
    chk("tmo_default_still_busy", mem_rd, 1);
    chk("tmo_default_no_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
